// File: rtl/csr_timer_intc_pkg.sv
// Shared CSR definitions for the timer/interrupt CSR slice: addresses,
// register layouts and bit positions used by the core and its CSR files.
package cpu_defs;

  typedef logic [13:0] csr_addr_t;

  localparam csr_addr_t CSR_TID   = 14'h0040;
  localparam csr_addr_t CSR_TCFG  = 14'h0041;
  localparam csr_addr_t CSR_TVAL  = 14'h0042;
  localparam csr_addr_t CSR_TICLR = 14'h0044;

  // Bit of the TICLR write data that clears the timer interrupt.
  localparam int TICLR_CLR = 0;

  // TCFG as seen at full 32-bit width; bits at or above the timer width
  // are held at zero by the timer itself.
  typedef struct packed {
    logic [29:0] initval;
    logic        periodic;
    logic        en;
  } tcfg_t;

  // ESTAT.IS image.
  typedef struct packed {
    logic       ipi;
    logic       ti;
    logic       r10;
    logic [7:0] hwi;
    logic [1:0] swi;
  } estat_is_t;

endpackage

// File: rtl/csr_timer_intc_sync_chain.sv
// Multi-flop synchroniser for a bundle of asynchronous level signals.
// Each bit is synchronised independently; no latching of pulses.
module sync_chain #(
  parameter int WID    = 1,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [WID-1:0] din,
  output logic [WID-1:0] dout
);

  logic [STAGES-1:0][WID-1:0] stage_r;

  // Shift the raw inputs through the synchroniser flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_r <= {(STAGES*WID){1'b0}};
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[STAGES-1];

endmodule

// File: rtl/csr_timer_intc.sv
// Timer and interrupt CSR slice: TID/TCFG/TVAL/TICLR, a countdown timer
// with one-shot and periodic modes, and aggregation of SWI/HWI/TI/IPI
// into the ESTAT.IS image and the masked interrupt request.
module csr_timer_intc
  import cpu_defs::*;
#(
  parameter int          TIMER_WID   = 32,
  parameter int          HWI_NUM     = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] CORE_ID     = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  csr_addr_t          addr,
  input  logic               we,
  input  logic [31:0]        wr_data,
  output logic [31:0]        rd_data,
  output logic               rd_hit,
  input  logic [HWI_NUM-1:0] hwi_i,
  input  logic               ipi_i,
  input  logic [1:0]         swi_i,
  input  logic [12:0]        lie_i,
  input  logic               crmd_ie_i,
  output logic [12:0]        is_o,
  output logic               ti_o,
  output logic               int_req_o
);

  localparam int SYNC_WID = HWI_NUM + 1;
  localparam logic [TIMER_WID-1:0] TVAL_ZERO = {TIMER_WID{1'b0}};

  logic [31:0]          tid_r;
  logic [TIMER_WID-1:0] tcfg_r;
  logic [TIMER_WID-1:0] tval_r;
  logic                 armed_r;
  logic                 ti_r;

  tcfg_t                tcfg_s;
  logic [TIMER_WID-1:0] reload_s;
  logic [TIMER_WID-1:0] wr_reload_s;
  logic                 tid_wr_s;
  logic                 tcfg_wr_s;
  logic                 ticlr_wr_s;
  logic                 count_s;
  logic                 expire_s;
  logic [SYNC_WID-1:0]  sync_s;
  logic [7:0]           hwi_ext_s;
  estat_is_t            is_s;

  // Decode CSR writes and derive the timer control terms.
  always_comb begin
    tcfg_s      = tcfg_t'(32'(tcfg_r));
    reload_s    = TIMER_WID'({tcfg_s.initval, 2'b00});
    wr_reload_s = {wr_data[TIMER_WID-1:2], 2'b00};
    tid_wr_s    = we & (addr == CSR_TID);
    tcfg_wr_s   = we & (addr == CSR_TCFG);
    ticlr_wr_s  = we & (addr == CSR_TICLR) & wr_data[TICLR_CLR];
    // A TCFG write takes priority over counting, so it can never expire.
    count_s     = tcfg_s.en & armed_r & ~tcfg_wr_s;
    expire_s    = count_s & (tval_r == TVAL_ZERO);
  end

  // Timer configuration, counter and arm state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcfg_r  <= {TIMER_WID{1'b0}};
      tval_r  <= {TIMER_WID{1'b0}};
      armed_r <= 1'b0;
    end else if (tcfg_wr_s) begin
      tcfg_r  <= wr_data[TIMER_WID-1:0];
      tval_r  <= wr_reload_s;
      armed_r <= 1'b1;
    end else if (count_s) begin
      if (tval_r != TVAL_ZERO) begin
        tval_r <= tval_r - TIMER_WID'(1'b1);
      end else if (tcfg_s.periodic) begin
        tval_r <= reload_s;
      end else begin
        armed_r <= 1'b0;
      end
    end
  end

  // Sticky timer interrupt; an expiry beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ti_r <= 1'b0;
    end else if (expire_s) begin
      ti_r <= 1'b1;
    end else if (ticlr_wr_s) begin
      ti_r <= 1'b0;
    end
  end

  // Timer ID register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tid_r <= CORE_ID;
    end else if (tid_wr_s) begin
      tid_r <= wr_data;
    end
  end

  sync_chain #(
    .WID    (SYNC_WID),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({ipi_i, hwi_i}),
    .dout  (sync_s)
  );

  // Assemble the ESTAT.IS image; unused HWI lines read zero.
  always_comb begin
    hwi_ext_s              = 8'h00;
    hwi_ext_s[HWI_NUM-1:0] = sync_s[HWI_NUM-1:0];
    is_s.swi               = swi_i;
    is_s.hwi               = hwi_ext_s;
    is_s.r10               = 1'b0;
    is_s.ti                = ti_r;
    is_s.ipi               = sync_s[HWI_NUM];
  end

  assign is_o      = is_s;
  assign ti_o      = ti_r;
  assign int_req_o = crmd_ie_i & (|(is_o & lie_i));

  // CSR read mux; reads see the value before any same-cycle write.
  always_comb begin
    rd_data = 32'h0000_0000;
    rd_hit  = 1'b1;
    case (addr)
      CSR_TID:   rd_data = tid_r;
      CSR_TCFG:  rd_data = 32'(tcfg_r);
      CSR_TVAL:  rd_data = 32'(tval_r);
      CSR_TICLR: rd_data = 32'h0000_0000;
      default:   rd_hit  = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_csr_timer_intc.sv
// Self-checking bench for csr_timer_intc: reset read table, directed timer
// and interrupt sequences, and randomized traffic against a reference model.
module tb_csr_timer_intc;

  localparam int          TW  = 16;
  localparam int          HN  = 6;
  localparam int          SS  = 2;
  localparam logic [31:0] CID = 32'h0000_00A7;
  localparam logic [31:0] MASK = 32'hFFFF_FFFF >> (32 - TW);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [13:0]   addr;
  logic          we;
  logic [31:0]   wr_data;
  logic [31:0]   rd_data;
  logic          rd_hit;
  logic [HN-1:0] hwi_i;
  logic          ipi_i;
  logic [1:0]    swi_i;
  logic [12:0]   lie_i;
  logic          crmd_ie_i;
  logic [12:0]   is_o;
  logic          ti_o;
  logic          int_req_o;

  always #5 clk = ~clk;

  csr_timer_intc #(
    .TIMER_WID   (TW),
    .HWI_NUM     (HN),
    .SYNC_STAGES (SS),
    .CORE_ID     (CID)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .we        (we),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .rd_hit    (rd_hit),
    .hwi_i     (hwi_i),
    .ipi_i     (ipi_i),
    .swi_i     (swi_i),
    .lie_i     (lie_i),
    .crmd_ie_i (crmd_ie_i),
    .is_o      (is_o),
    .ti_o      (ti_o),
    .int_req_o (int_req_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [31:0] m_tid, m_tcfg, m_tval;
  bit          m_armed, m_ti;
  logic [HN:0] sq[$];  // input history, newest first

  typedef struct {
    logic [13:0] a;
    logic [31:0] d;
    logic        h;
  } rvec_t;
  rvec_t tbl[6];

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_tid   = CID;
    m_tcfg  = 32'd0;
    m_tval  = 32'd0;
    m_armed = 1'b0;
    m_ti    = 1'b0;
    sq.delete();
    for (int i = 0; i < SS; i++) sq.push_back({(HN+1){1'b0}});
  endfunction

  // One clock edge of the reference model, from the rules of the CSRs.
  function automatic void model_update();
    bit          expd;
    logic [31:0] r;
    if (!rst_n) begin
      model_reset();
      return;
    end
    sq.push_front({ipi_i, hwi_i});
    sq.delete(SS);
    expd = 1'b0;
    r    = m_tcfg & ~32'h3;
    if (we && addr == 14'h41) begin
      m_tcfg  = wr_data & MASK;
      m_tval  = m_tcfg & ~32'h3;
      m_armed = 1'b1;
    end else if (m_tcfg[0] && m_armed) begin
      if (m_tval != 32'd0) m_tval = m_tval - 32'd1;
      else begin
        expd = 1'b1;
        m_ti = 1'b1;
        if (m_tcfg[1]) m_tval = r;
        else m_armed = 1'b0;
      end
    end
    if (we && addr == 14'h44 && wr_data[0] && !expd) m_ti = 1'b0;
    if (we && addr == 14'h40) m_tid = wr_data;
  endfunction

  function automatic void check_all();
    logic [31:0] e_rd;
    logic        e_hit;
    logic [12:0] e_is;
    logic [HN:0] s;
    s     = sq[SS-1];
    e_rd  = 32'd0;
    e_hit = 1'b1;
    case (addr)
      14'h40:  e_rd = m_tid;
      14'h41:  e_rd = m_tcfg;
      14'h42:  e_rd = m_tval;
      14'h44:  e_rd = 32'd0;
      default: e_hit = 1'b0;
    endcase
    e_is = 13'(swi_i) | (13'(s[HN-1:0]) << 2) | (13'(m_ti) << 11) | (13'(s[HN]) << 12);
    check("rd_data", rd_data, e_rd);
    check("rd_hit", 32'(rd_hit), 32'(e_hit));
    check("is_o", 32'(is_o), 32'(e_is));
    check("ti_o", 32'(ti_o), 32'(m_ti));
    check("int_req", 32'(int_req_o), 32'(crmd_ie_i && ((e_is & lie_i) != 13'd0)));
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic step();
    #1 check_all();
    tick();
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    addr = a; we = 1'b1; wr_data = d;
    step();
    we = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [13:0] a, input logic [31:0] exp);
    addr = a;
    #1 check(nm, rd_data, exp);
    check_all();
    tick();
  endtask

  // Steps until ti_o is seen, bounded; returns the number of edges taken.
  task automatic wait_ti(output int n);
    n = 0;
    while (!ti_o && n < 200) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; addr = 14'h0; we = 1'b0; wr_data = 32'd0;
    hwi_i = '0; ipi_i = 1'b0; swi_i = 2'b00; lie_i = 13'd0; crmd_ie_i = 1'b0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset-state reads.
    tbl[0] = '{14'h0040, CID,   1'b1};
    tbl[1] = '{14'h0041, 32'd0, 1'b1};
    tbl[2] = '{14'h0042, 32'd0, 1'b1};
    tbl[3] = '{14'h0044, 32'd0, 1'b1};
    tbl[4] = '{14'h0043, 32'd0, 1'b0};
    tbl[5] = '{14'h3FFF, 32'd0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      addr = tbl[i].a;
      #1;
      check("reset_rd", rd_data, tbl[i].d);
      check("reset_hit", 32'(rd_hit), 32'(tbl[i].h));
      check("reset_ti", 32'(ti_o), 32'd0);
      check_all();
      tick();
    end

    // One-shot, R=0x10.
    wr(14'h41, 32'h0000_0011);
    addr = 14'h42;
    #1 check("oneshot_load", rd_data, 32'h10);
    wait_ti(n);
    check("oneshot_latency", 32'(n), 32'd17);
    repeat (50) step();
    check("oneshot_hold_tval", rd_data, 32'd0);
    check("oneshot_hold_ti", 32'(ti_o), 32'd1);

    // Periodic, R=8: expiries every 9 edges.
    wr(14'h44, 32'h1);
    wr(14'h41, 32'h0000_000B);
    wait_ti(n);
    check("periodic_first", 32'(n), 32'd9);
    wr(14'h44, 32'h1);
    check("ticlr_clears", 32'(ti_o), 32'd0);
    wait_ti(n);
    check("periodic_second", 32'(n), 32'd8);
    wr(14'h44, 32'h1);
    repeat (7) step();
    wr(14'h44, 32'h1);
    check("clr_vs_expiry", 32'(ti_o), 32'd1);

    // en=0 freezes at the reload value.
    wr(14'h44, 32'h1);
    wr(14'h41, 32'h0000_0010);
    addr = 14'h42;
    repeat (20) step();
    check("frozen_tval", rd_data, 32'h10);
    check("frozen_ti", 32'(ti_o), 32'd0);

    // TCFG write in the expiry cycle: no TI, new reload.
    wr(14'h41, 32'h0000_0009);
    addr = 14'h42;
    repeat (8) step();
    check("pre_expiry_tval", rd_data, 32'd0);
    wr(14'h41, 32'h0000_0015);
    addr = 14'h42;
    #1;
    check("cfg_at_expiry_ti", 32'(ti_o), 32'd0);
    check("cfg_at_expiry_tval", rd_data, 32'h14);
    @(negedge clk);
    wr(14'h41, 32'h0000_0000);

    // Hardware interrupt synchronisation and masking.
    addr = 14'h43;
    hwi_i = 6'b001000;
    step();
    check("hwi_lat1", 32'(is_o[5]), 32'd0);
    step();
    check("hwi_lat2", 32'(is_o[5]), 32'd1);
    lie_i = 13'h0020; crmd_ie_i = 1'b1;
    #1 check("int_req_on", 32'(int_req_o), 32'd1);
    crmd_ie_i = 1'b0;
    #1 check("int_req_ie_off", 32'(int_req_o), 32'd0);
    @(negedge clk);
    hwi_i = '0;
    step();
    check("hwi_drop1", 32'(is_o[5]), 32'd1);
    step();
    check("hwi_drop2", 32'(is_o[5]), 32'd0);

    // Width masking, then asynchronous reset mid-count.
    wr(14'h40, 32'h1234_5678);
    wr(14'h41, 32'hFFFF_FFFF);
    rd_chk("tcfg_masked", 14'h41, 32'h0000_FFFF);
    rd_chk("tval_masked", 14'h42, 32'h0000_FFFB);
    repeat (5) step();
    #3 rst_n = 1'b0;
    addr = 14'h41;
    #1 check("arst_tcfg", rd_data, 32'd0);
    addr = 14'h42;
    #1 check("arst_tval", rd_data, 32'd0);
    addr = 14'h40;
    #1 check("arst_tid", rd_data, CID);
    check("arst_ti", 32'(ti_o), 32'd0);
    model_reset();
    @(negedge clk);
    step();
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      we = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0: addr = 14'h40;
        1: addr = 14'h41;
        2: addr = 14'h42;
        3: addr = 14'h43;
        4: addr = 14'h44;
        default: addr = 14'($urandom);
      endcase
      wr_data = (addr == 14'h41) ? ($urandom & 32'hFFC0_003F) : $urandom;
      if ($urandom_range(0, 7) == 0) hwi_i = HN'($urandom);
      if ($urandom_range(0, 7) == 0) ipi_i = 1'($urandom);
      swi_i     = 2'($urandom);
      lie_i     = 13'($urandom);
      crmd_ie_i = 1'($urandom);
      step();
    end
    we = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
